// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_arb_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  // r0 is hard-wired to zero; writes to it are accepted but never committed.
  localparam logic [RF_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_wr_arbiter_starve_ctr.sv
// Starvation counter: counts consecutive cycles the MDU loses arbitration and
// flags the cycle whose loss must turn into a forced MDU grant next cycle.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic force_next
);

  localparam logic [3:0] LAST_CNT = 4'(STARVE_MAX - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    force_next = inc & ~clr & (cnt_q == LAST_CNT);
    cnt_d      = cnt_q;
    // The forced grant itself clears the count, so restart from zero here.
    if (clr || force_next) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester (WB fixed priority, MDU with starvation guard) arbiter for the
// register file write port. Optional MDU wait statistics: REGFILE_ARB_STATS_EN.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef REGFILE_ARB_STATS_EN
  output logic [15:0]       stat_mdu_wait,
`endif
  output logic              wb_stall
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  arb_state_t        state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              collision;
  logic              mdu_lost;
  logic              starve_clr;
  logic              force_next;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .inc       (mdu_lost),
    .clr       (starve_clr),
    .force_next(force_next)
  );

  always_comb begin
    collision = wb_valid & mdu_valid & (wb_addr == mdu_addr);
    if (state_q == NORMAL) begin
      wb_ready  = wb_valid;
      // Same-address collision: both retire, the WB (younger) write wins.
      mdu_ready = mdu_valid & (~wb_valid | collision);
    end else begin
      wb_ready  = 1'b0;
      mdu_ready = mdu_valid;
    end
    wb_stall   = wb_valid & ~wb_ready;
    mdu_lost   = mdu_valid & ~mdu_ready;
    starve_clr = (state_q == FORCE) | ~mdu_valid | mdu_ready;
    state_d    = force_next ? FORCE : NORMAL;

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wb_ready) begin
      rf_we_d    = (wb_addr != ZERO_ADDR);
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
    end else if (mdu_ready) begin
      rf_we_d    = (mdu_addr != ZERO_ADDR);
      rf_waddr_d = mdu_addr;
      rf_wdata_d = mdu_data;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    // A dropped collision write counts as a wait cycle for the MDU as well.
    if ((mdu_lost || (collision && state_q == NORMAL)) && stat_q != 16'hFFFF) begin
      stat_d = stat_q + 16'd1;
    end
  end

  assign stat_mdu_wait = stat_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NORMAL;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
`ifdef REGFILE_ARB_STATS_EN
      stat_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
`ifdef REGFILE_ARB_STATS_EN
      stat_q     <= stat_d;
`endif
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// random traffic, compared against a cycle-level behavioural model.
module tb_regfile_wr_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, mdu_valid;
  logic [4:0]  wb_addr, mdu_addr;
  logic [31:0] wb_data, mdu_data;
  logic        wb_ready, mdu_ready, rf_we, wb_stall;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stat_mdu_wait;
`endif

  regfile_wr_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef REGFILE_ARB_STATS_EN
    .stat_mdu_wait(stat_mdu_wait),
`endif
    .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          m_lost_run;
  bit          m_force;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_stat;
  logic [31:0] m_rf [32];
  logic [31:0] dut_rf [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lost_run = 0;
    m_force    = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    m_stat     = 0;
  endtask

  // One clock of traffic: entered just after a negedge, leaves at the next negedge.
  task automatic cycle(input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       output bit mr);
    bit          ewr, emr, coll, lost;
    bit          p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    p_we = rf_we; p_addr = rf_waddr; p_data = rf_wdata;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    #1;
    if (m_force) begin
      ewr = 1'b0;
      emr = mv;
    end else begin
      ewr = wv;
      emr = mv && (!wv || wa == ma);
    end
    coll = !m_force && wv && mv && (wa == ma);
    lost = mv && !emr;
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, ewr});
    chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, emr});
    chk("wb_stall", {31'd0, wb_stall}, {31'd0, wv && !ewr});
    @(posedge clk);
    if (p_we) dut_rf[p_addr] = p_data;
    if (m_we) m_rf[m_addr] = m_data;
    if (ewr) begin
      m_we = (wa != 5'd0); m_addr = wa; m_data = wd;
    end else if (emr) begin
      m_we = (ma != 5'd0); m_addr = ma; m_data = md;
    end else begin
      m_we = 1'b0;
    end
    if ((lost || coll) && m_stat < 65535) m_stat++;
    if (m_force) begin
      m_force = 1'b0;
      m_lost_run = 0;
    end else if (lost) begin
      m_lost_run++;
      if (m_lost_run == STARVE_MAX) begin
        m_force = 1'b1;
        m_lost_run = 0;
      end
    end else begin
      m_lost_run = 0;
    end
    #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_addr});
    chk("rf_wdata", rf_wdata, m_data);
`ifdef REGFILE_ARB_STATS_EN
    chk("stat_mdu_wait", {16'd0, stat_mdu_wait}, m_stat[31:0]);
`endif
    @(negedge clk);
    mr = emr;
  endtask

  initial begin
    bit          mr;
    bit          pend;
    logic [4:0]  pa;
    logic [31:0] pd;
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      dut_rf[i] = '0;
    end
    model_reset();
    rst = 1'b1;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
    repeat (2) @(negedge clk);
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    rst = 1'b0;

    // WB alone
    cycle(1, 5'd5, 32'hA5A5, 0, 5'd0, 32'd0, mr);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mr);
    // Starvation: WB wins STARVE_MAX cycles, then MDU is forced through
    for (int i = 0; i < STARVE_MAX + 2; i++)
      cycle(1, 5'd3, 32'h100 + i, 1, 5'd7, 32'h7777, mr);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mr);
    // Same-address collision
    cycle(1, 5'd9, 32'd1, 1, 5'd9, 32'd2, mr);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mr);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mr);
    // MDU to r0
    cycle(0, 5'd0, 32'd0, 1, 5'd0, 32'hDEAD, mr);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mr);

    // Reach FORCE, then reset asynchronously in the middle of that cycle
    for (int i = 0; i < STARVE_MAX; i++)
      cycle(1, 5'd3, 32'h200 + i, 1, 5'd7, 32'h7070, mr);
    wb_valid = 1; wb_addr = 5'd3; mdu_valid = 1; mdu_addr = 5'd7;
    #2;
    chk("force_mdu_ready", {31'd0, mdu_ready}, 32'd1);
    chk("force_wb_stall", {31'd0, wb_stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_state_normal", {31'd0, wb_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // After reset WB goes first; MDU blocked 3 cycles then a collision
    for (int i = 0; i < 3; i++)
      cycle(1, 5'd1, 32'h300 + i, 1, 5'd2, 32'h2222, mr);
    cycle(1, 5'd2, 32'h400, 1, 5'd2, 32'h2222, mr);
`ifdef REGFILE_ARB_STATS_EN
    chk("stat_after_block3_coll", {16'd0, stat_mdu_wait}, 32'd4);
`endif

    // Random traffic; the MDU holds its request until accepted
    pend = 0; pa = 0; pd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        pend = 1;
        pa = 5'($urandom_range(0, 7));
        pd = $urandom;
      end
      cycle(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            pend, pa, pd, mr);
      if (mr) pend = 0;
    end
    repeat (2) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, mr);

    for (int i = 0; i < 32; i++)
      chk($sformatf("rf_contents[%0d]", i), dut_rf[i], m_rf[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
